imem: RTL and testbench

IMEM -- requirements
Module: imem

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_rom.sv | 19 +
 rtl/imem.sv | 42 ++++
 tb/tb_imem.sv | 138 +++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: ROM depth and contents shared by the instruction memory.
// ROM_W is the native width of the stored words.
package imem_pkg;

  localparam int ROM_DEPTH = 47;
  localparam int ROM_W     = 32;

  localparam logic [ROM_W-1:0] ROM [0:ROM_DEPTH-1] = '{
    32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083,
    32'hf8018003, 32'hcb050083, 32'hf8020003, 32'hcb0a03e4,
    32'hf8028004, 32'h8b040064, 32'hf8030004, 32'hcb030025,
    32'hf8038005, 32'h8a1f0145, 32'hf8040005, 32'h8a030145,
    32'hf8048005, 32'h8a140294, 32'hf8050014, 32'haa1f0166,
    32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c,
    32'h8b1f0187, 32'hf8068007, 32'hf807000c, 32'h8b0e01bf,
    32'hf807801f, 32'hb4000040, 32'hf8080015, 32'hf8088015,
    32'h8b0103e2, 32'hcb010042, 32'h8b0103f8, 32'hf8090018,
    32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de,
    32'hcb1503f5, 32'h8b1403de, 32'hf85f83d9, 32'h8b1e03de,
    32'h8b1003de, 32'hf81f83d9, 32'hb400001f
  };

  function automatic logic in_rom(input int a);
    return a < ROM_DEPTH;
  endfunction

endpackage

// File: rtl/imem_rom.sv
// imem_rom: combinational word lookup, zero above ROM_DEPTH.
// Ports: addr (word address) -> q (N-bit instruction word).
module imem_rom
  import imem_pkg::*;
#(
  parameter int N      = 32,
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N-1:0]      q
);

  always_comb begin
    q = '0;
    if (in_rom(int'(addr)))
      q = N'(ROM[int'(addr)]);
  end

endmodule

// File: rtl/imem.sv
// imem: read-only instruction memory with out-of-range status.
// Ports: clk, reset_n, addr -> q, oob, oob_sticky. Macro: IMEM_OOB_STATUS_EN.
module imem
  import imem_pkg::*;
#(
  parameter int N      = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  output logic [N-1:0]      q,
  output logic              oob,
  output logic              oob_sticky
);

  imem_rom #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .addr (addr),
    .q    (q)
  );

`ifdef IMEM_OOB_STATUS_EN
  assign oob = !in_rom(int'(addr));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      oob_sticky <= 1'b0;
    else
      oob_sticky <= oob_sticky | oob;
  end
`else
  // Status disabled: ports kept, tied low, clock/reset unused.
  logic unused_status;
  assign unused_status = clk ^ reset_n;
  assign oob           = 1'b0;
  assign oob_sticky    = 1'b0;
`endif

endmodule

// File: tb/tb_imem.sv
// tb_imem: directed + random checks of imem against a table model.
// Status expectations follow IMEM_OOB_STATUS_EN.
module tb_imem;

  localparam int N  = 32;
  localparam int AW = 6;

`ifdef IMEM_OOB_STATUS_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] addr;
  logic [N-1:0]  q;
  logic          oob;
  logic          oob_sticky;

  int checks = 0;
  int errors = 0;
  bit m_sticky;

  logic [31:0] tbl [0:46] = '{
    32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083,
    32'hf8018003, 32'hcb050083, 32'hf8020003, 32'hcb0a03e4,
    32'hf8028004, 32'h8b040064, 32'hf8030004, 32'hcb030025,
    32'hf8038005, 32'h8a1f0145, 32'hf8040005, 32'h8a030145,
    32'hf8048005, 32'h8a140294, 32'hf8050014, 32'haa1f0166,
    32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c,
    32'h8b1f0187, 32'hf8068007, 32'hf807000c, 32'h8b0e01bf,
    32'hf807801f, 32'hb4000040, 32'hf8080015, 32'hf8088015,
    32'h8b0103e2, 32'hcb010042, 32'h8b0103f8, 32'hf8090018,
    32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de,
    32'hcb1503f5, 32'h8b1403de, 32'hf85f83d9, 32'h8b1e03de,
    32'h8b1003de, 32'hf81f83d9, 32'hb400001f
  };

  imem #(.N(N), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .addr       (addr),
    .q          (q),
    .oob        (oob),
    .oob_sticky (oob_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_q(input int a);
    return (a < 47) ? tbl[a] : 32'h0;
  endfunction

  function automatic logic exp_oob(input int a);
    return EN && (a >= 47);
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_q"}, 64'(q), 64'(exp_q(int'(addr))));
    check({tag, "_oob"}, 64'(oob), 64'(exp_oob(int'(addr))));
    check({tag, "_stk"}, 64'(oob_sticky), 64'(m_sticky));
  endtask

  // Drive addr at the falling edge, let one rising edge sample it.
  task automatic step(input int a);
    @(negedge clk);
    addr = AW'(a);
    @(posedge clk);
    if (reset_n) m_sticky = m_sticky | exp_oob(a);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    addr     = '0;
    m_sticky = 1'b0;
    #12;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 47; i++) begin
      step(i);
      check_all("sweep");
    end
    check("sweep_q0", 64'(exp_q(0)), 64'h00000000f8000001);

    step(47); check_all("a47");
    check("a47_stk_set", 64'(oob_sticky), 64'(EN));
    step(48); check_all("a48");
    step(63); check_all("a63");
    step(5);  check_all("back5");
    check("back5_q", 64'(q), 64'h00000000cb050083);
    step(6);  check_all("stay");

    @(negedge clk);
    #2 reset_n = 1'b0;
    m_sticky = 1'b0;
    #1 check_all("rst_pulse");
    check("rst_pulse_q", 64'(q), 64'h00000000f8020003);
    #1 reset_n = 1'b1;

    @(negedge clk);
    addr = 0;
    #1 check("mid_q0", 64'(q), 64'h00000000f8000001);
    addr = 1;
    #0 check("mid_q1", 64'(q), 64'h00000000f8008002);
    #1 check_all("mid");

    for (int i = 0; i < 300; i++) begin
      step(int'($urandom_range(0, 63)));
      check_all("rand");
    end

    step(50); check_all("a50");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
